// File: rtl/pio_in_debounce_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_pkg
//  Description : Shared constants and helpers for the debounced input PIO:
//                register word addresses and debounce counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_RAW       = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN   = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN   = 3'd5;
  localparam logic [2:0] ADDR_LEVEL_SEL = 3'd6;
  localparam logic [2:0] ADDR_RESERVED  = 3'd7;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    if (cycles < 1) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage : pio_pkg
`default_nettype wire

// File: rtl/pio_in_debounce_irq_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : pio_debounce_bit
//  Description : One input bit: synchroniser chain, counter debouncer,
//                previous-value register and qualified rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  input  logic rise_en,
  input  logic fall_en,
  output logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_bit};
  end

  assign raw = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = raw;
    end else begin : g_counter
      localparam int             CW     = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_stable;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (raw == r_stable) begin
          r_cnt    <= '0;
        end else if (r_cnt == C_LAST) begin
          r_stable <= raw;
          r_cnt    <= '0;
        end else begin
          r_cnt    <= r_cnt + 1'b1;
        end
      end

      assign stable = r_stable;
    end
  endgenerate

  // Remember last cycle's debounced level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= 1'b0;
    else          r_prev <= stable;
  end

  assign rise = stable & ~r_prev & rise_en;
  assign fall = ~stable & r_prev & fall_en;

endmodule : pio_debounce_bit
`default_nettype wire

// File: rtl/pio_in_debounce_irq.sv
`default_nettype none
// ============================================================================
//  Module      : pio_in_debounce_irq
//  Description : Avalon-MM input PIO with per-bit synchronisation,
//                debouncing and edge/level interrupt generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_in_debounce_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_raw, w_stable, w_rise, w_fall;
  logic [WIDTH-1:0] r_irq_mask, r_edge_cap, r_rise_en, r_fall_en, r_level_sel;
  logic [WIDTH-1:0] w_wdata, w_clr, w_irq_src;
  logic [31:0]      w_rd;
  logic             w_wr;
  logic             w_unused_wdata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk    (clk),
        .reset_n(reset_n),
        .in_bit (in_port[i]),
        .rise_en(r_rise_en[i]),
        .fall_en(r_fall_en[i]),
        .raw    (w_raw[i]),
        .stable (w_stable[i]),
        .rise   (w_rise[i]),
        .fall   (w_fall[i])
      );
    end
  endgenerate

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_clr          = (w_wr && address == ADDR_EDGE_CAP) ? w_wdata : '0;

  // Control register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask  <= '0;
      r_rise_en   <= '0;
      r_fall_en   <= '1;
      r_level_sel <= '0;
    end else if (w_wr) begin
      if (address == ADDR_IRQ_MASK)  r_irq_mask  <= w_wdata;
      if (address == ADDR_RISE_EN)   r_rise_en   <= w_wdata;
      if (address == ADDR_FALL_EN)   r_fall_en   <= w_wdata;
      if (address == ADDR_LEVEL_SEL) r_level_sel <= w_wdata;
    end
  end

  // Edge capture: W1C clears, but a same-cycle event wins so none is lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edge_cap <= '0;
    else          r_edge_cap <= (r_edge_cap & ~w_clr) | w_rise | w_fall;
  end

  // Read mux; unused upper bits stay zero
  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:      w_rd[WIDTH-1:0] = w_stable;
      ADDR_RAW:       w_rd[WIDTH-1:0] = w_raw;
      ADDR_IRQ_MASK:  w_rd[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE_CAP:  w_rd[WIDTH-1:0] = r_edge_cap;
      ADDR_RISE_EN:   w_rd[WIDTH-1:0] = r_rise_en;
      ADDR_FALL_EN:   w_rd[WIDTH-1:0] = r_fall_en;
      ADDR_LEVEL_SEL: w_rd[WIDTH-1:0] = r_level_sel;
      default:        w_rd = '0;
    endcase
  end

  // Register read data every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd;
  end

  assign w_irq_src = (r_edge_cap & ~r_level_sel) | (w_stable & r_level_sel);

  // Registered interrupt request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(w_irq_src & r_irq_mask);
  end

endmodule : pio_in_debounce_irq
`default_nettype wire

// File: tb/tb_pio_in_debounce_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_in_debounce_irq
//  Description : Self-checking bench for pio_in_debounce_irq, using one
//                instance without debouncing and one with a 4-cycle debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_in_debounce_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address0, address4;
  logic        chipselect0, chipselect4, write_n0, write_n4;
  logic [31:0] writedata0, writedata4, readdata0, readdata4;
  logic [17:0] in_port0, in_port4;
  logic        irq0, irq4;
  logic [31:0] rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pio_in_debounce_irq #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address0), .chipselect(chipselect0),
    .write_n(write_n0), .writedata(writedata0), .readdata(readdata0),
    .in_port(in_port0), .irq(irq0)
  );

  pio_in_debounce_irq #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .address(address4), .chipselect(chipselect4),
    .write_n(write_n4), .writedata(writedata4), .readdata(readdata4),
    .in_port(in_port4), .irq(irq4)
  );

  typedef struct {
    bit          wr;
    bit          cs;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input int sel, input logic [2:0] a, input logic [31:0] d, input logic cs);
    @(negedge clk);
    if (sel == 0) begin
      address0 = a; chipselect0 = cs; write_n0 = 1'b0; writedata0 = d;
    end else begin
      address4 = a; chipselect4 = cs; write_n4 = 1'b0; writedata4 = d;
    end
    @(negedge clk);
    chipselect0 = 1'b0; write_n0 = 1'b1;
    chipselect4 = 1'b0; write_n4 = 1'b1;
  endtask

  task automatic bus_read(input int sel, input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    if (sel == 0) address0 = a;
    else          address4 = a;
    @(posedge clk);
    #1;
    d = (sel == 0) ? readdata0 : readdata4;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Register access table for the undebounced instance (in_port held at 0)
    tbl[0]  = '{0, 1, 3'd5, 32'h0,        32'h3FFFF};
    tbl[1]  = '{0, 1, 3'd2, 32'h0,        32'h0};
    tbl[2]  = '{0, 1, 3'd3, 32'h0,        32'h0};
    tbl[3]  = '{0, 1, 3'd4, 32'h0,        32'h0};
    tbl[4]  = '{0, 1, 3'd6, 32'h0,        32'h0};
    tbl[5]  = '{0, 1, 3'd7, 32'h0,        32'h0};
    tbl[6]  = '{0, 1, 3'd0, 32'h0,        32'h0};
    tbl[7]  = '{0, 1, 3'd1, 32'h0,        32'h0};
    tbl[8]  = '{1, 1, 3'd2, 32'hFFFFFFFF, 32'h3FFFF};
    tbl[9]  = '{1, 0, 3'd2, 32'h0,        32'h3FFFF};
    tbl[10] = '{1, 1, 3'd2, 32'h0,        32'h0};
    tbl[11] = '{1, 1, 3'd4, 32'h12345,    32'h12345};
    tbl[12] = '{1, 1, 3'd4, 32'h0,        32'h0};
    tbl[13] = '{1, 1, 3'd6, 32'hABCDE,    32'h2BCDE};
    tbl[14] = '{1, 1, 3'd6, 32'h0,        32'h0};
    tbl[15] = '{1, 1, 3'd7, 32'hFFFF,     32'h0};
    tbl[16] = '{1, 1, 3'd5, 32'h0,        32'h0};
    tbl[17] = '{1, 1, 3'd5, 32'hFFFFFFFF, 32'h3FFFF};
    tbl[18] = '{1, 1, 3'd3, 32'hFFFFFFFF, 32'h0};

    reset_n = 1'b0;
    address0 = '0; chipselect0 = 1'b0; write_n0 = 1'b1; writedata0 = '0; in_port0 = '0;
    address4 = '0; chipselect4 = 1'b0; write_n4 = 1'b1; writedata4 = '0; in_port4 = '0;
    #2;
    check("reset_readdata", readdata0, 32'h0);
    check("reset_irq", {31'h0, irq0}, 32'h0);
    wait_cyc(3);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) bus_write(0, tbl[i].addr, tbl[i].wdata, tbl[i].cs);
      bus_read(0, tbl[i].addr, rd);
      check($sformatf("tbl[%0d]", i), rd, tbl[i].exp);
    end

    // Falling edge on bit 3 at reset defaults
    in_port0[3] = 1'b1;
    wait_cyc(5);
    bus_read(0, 3'd0, rd); check("b3_data_hi", rd, 32'h8);
    bus_read(0, 3'd1, rd); check("b3_raw_hi", rd, 32'h8);
    bus_read(0, 3'd3, rd); check("b3_no_rise_cap", rd, 32'h0);
    in_port0[3] = 1'b0;
    wait_cyc(5);
    bus_read(0, 3'd3, rd); check("b3_fall_cap", rd, 32'h8);
    bus_read(0, 3'd0, rd); check("b3_data_lo", rd, 32'h0);
    check("b3_irq_masked", {31'h0, irq0}, 32'h0);
    bus_write(0, 3'd2, 32'h8, 1'b1);
    @(posedge clk); #1;
    check("b3_irq_set", {31'h0, irq0}, 32'h1);
    bus_write(0, 3'd3, 32'h8, 1'b1);
    @(posedge clk); #1;
    check("b3_irq_clr", {31'h0, irq0}, 32'h0);
    bus_read(0, 3'd3, rd); check("b3_cap_clr", rd, 32'h0);

    // Any-edge mode on bit 1
    bus_write(0, 3'd4, 32'h2, 1'b1);
    bus_write(0, 3'd5, 32'h2, 1'b1);
    in_port0[1] = 1'b1;
    wait_cyc(5);
    bus_read(0, 3'd3, rd); check("any_rise_cap", rd, 32'h2);
    bus_write(0, 3'd3, 32'h2, 1'b1);
    bus_read(0, 3'd3, rd); check("any_clr1", rd, 32'h0);
    in_port0[1] = 1'b0;
    wait_cyc(5);
    bus_read(0, 3'd3, rd); check("any_fall_cap", rd, 32'h2);
    bus_write(0, 3'd3, 32'h2, 1'b1);
    bus_read(0, 3'd3, rd); check("any_clr2", rd, 32'h0);

    // Enabling rise after the level is already high creates no event
    bus_write(0, 3'd4, 32'h0, 1'b1);
    in_port0[1] = 1'b1;
    wait_cyc(5);
    bus_write(0, 3'd4, 32'h2, 1'b1);
    wait_cyc(3);
    bus_read(0, 3'd3, rd); check("no_retro_event", rd, 32'h0);

    // Level mode on bit 0
    bus_write(0, 3'd6, 32'h1, 1'b1);
    bus_write(0, 3'd2, 32'h1, 1'b1);
    @(posedge clk); #1;
    check("lvl_irq_lo0", {31'h0, irq0}, 32'h0);
    in_port0[0] = 1'b1;
    wait_cyc(5);
    check("lvl_irq_hi", {31'h0, irq0}, 32'h1);
    bus_write(0, 3'd3, 32'h3FFFF, 1'b1);
    @(posedge clk); #1;
    check("lvl_irq_w1c_noeffect", {31'h0, irq0}, 32'h1);
    in_port0[0] = 1'b0;
    wait_cyc(5);
    check("lvl_irq_lo1", {31'h0, irq0}, 32'h0);
    bus_write(0, 3'd6, 32'h0, 1'b1);
    bus_write(0, 3'd2, 32'h0, 1'b1);

    // W1C in the same cycle as the bit-1 fall event: the set must win
    @(negedge clk); in_port0[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    address0 = 3'd3; chipselect0 = 1'b1; write_n0 = 1'b0; writedata0 = 32'h2;
    @(negedge clk);
    chipselect0 = 1'b0; write_n0 = 1'b1;
    bus_read(0, 3'd3, rd); check("collision_set_wins", rd, 32'h2);

    // Debounced instance: 3-cycle glitch must be rejected
    bus_write(1, 3'd4, 32'h1, 1'b1);
    @(negedge clk); in_port4[0] = 1'b1;
    wait_cyc(3);
    in_port4[0] = 1'b0;
    wait_cyc(8);
    bus_read(1, 3'd0, rd); check("glitch_data", rd, 32'h0);
    bus_read(1, 3'd3, rd); check("glitch_cap", rd, 32'h0);

    // Held high: accepted only after the debounce period
    @(negedge clk); in_port4[0] = 1'b1;
    wait_cyc(2);
    bus_read(1, 3'd0, rd); check("deb_data_early", rd, 32'h0);
    wait_cyc(6);
    bus_read(1, 3'd0, rd); check("deb_data_hi", rd, 32'h1);
    bus_read(1, 3'd3, rd); check("deb_rise_cap", rd, 32'h1);
    bus_write(1, 3'd2, 32'h1, 1'b1);
    @(posedge clk); #1;
    check("deb_irq", {31'h0, irq4}, 32'h1);

    // Asynchronous reset in the middle of a debounce count on bit 2
    @(negedge clk); in_port4[2] = 1'b1;
    wait_cyc(4);
    #2 reset_n = 1'b0;
    #1;
    check("rst_readdata4", readdata4, 32'h0);
    check("rst_irq4", {31'h0, irq4}, 32'h0);
    check("rst_irq0", {31'h0, irq0}, 32'h0);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    bus_write(1, 3'd4, 32'h5, 1'b1);
    bus_read(1, 3'd3, rd); check("post_rst_cap_early", rd, 32'h0);
    bus_read(1, 3'd0, rd); check("post_rst_data_early", rd, 32'h0);
    wait_cyc(6);
    bus_read(1, 3'd0, rd); check("post_rst_data", rd, 32'h5);
    bus_read(1, 3'd3, rd); check("post_rst_cap", rd, 32'h5);
    check("post_rst_irq4", {31'h0, irq4}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pio_in_debounce_irq
`default_nettype wire
